// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for the multi-port register file:
//               controller state encoding and the write-port priority select.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Controller states; reset itself is the rst=0 condition, not a state.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Upper bound on write ports handled by the priority select.
    localparam int MAX_PORTS = 16;
    localparam int SEL_W     = 4;

    // Index of the highest set bit (highest-index port has priority).
    // Returns 0 when no bit is set; callers qualify with |hits.
    function automatic logic [SEL_W-1:0] prio_sel(input logic [MAX_PORTS-1:0] hits);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (hits[i]) sel = SEL_W'(i);
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_ctl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clear_ctl
// Description : Clear-sweep controller. After reset or on clear_req it walks
//               every register address once, then declares the file ready.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_clear_ctl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx;
    logic              ready_nx;

    // State, pointer and ready registers; active-low reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            ready <= ready_nx;
        end
    end

    // Next-state logic: sweep ends on the terminal address, not on overflow.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        ready_nx = ready;
        case (state)
            ST_CLEAR: begin
                ptr_nx = ptr + 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_nx = ST_RUN;
                    ptr_nx   = '0;
                    ready_nx = 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_nx = ST_CLEAR;
                    ptr_nx   = '0;
                    ready_nx = 1'b0;
                end
            end
        endcase
    end

    // No array write while reset is held; contents are only touched by the sweep.
    assign clr_en   = rst && (state == ST_CLEAR);
    assign clr_addr = ptr;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with fixed-priority
//               write ports, per-port write-to-read bypass, optional hard
//               zero register and a hardware clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    output logic                     ready,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              write_ok;

    regfile_clear_ctl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctl (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // ready is high exactly in RUN; writes are silently dropped otherwise.
    assign write_ok = rst && ready;

    // Storage: sweep clears one entry per cycle; in RUN later ports override earlier ones.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs[clr_addr] <= '0;
        end else if (write_ok) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we[p] && !(ZERO_REG != 0 && waddr[p*ADDR_W +: ADDR_W] == '0)) begin
                    regs[waddr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            logic [ADDR_W-1:0]    ra;
            logic [MAX_PORTS-1:0] hits;
            logic [SEL_W-1:0]     sel;
            logic [DATA_W-1:0]    fwd;
            logic [DATA_W-1:0]    val;

            assign ra = raddr[r*ADDR_W +: ADDR_W];

            // Which write ports target this read address in the current cycle.
            always_comb begin
                hits = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    hits[p] = we[p] && (waddr[p*ADDR_W +: ADDR_W] == ra);
                end
            end

            // Read mux in priority order: gate, enable, zero reg, bypass, storage.
            always_comb begin
                sel = prio_sel(hits);
                fwd = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (SEL_W'(p) == sel) fwd = wdata[p*DATA_W +: DATA_W];
                end
                val = regs[ra];
                if (!rst || !ready) begin
                    val = '0;
                end else if (!re[r]) begin
                    val = '0;
                end else if (ZERO_REG != 0 && ra == '0) begin
                    val = '0;
                end else if (BYPASS != 0 && (|hits)) begin
                    val = fwd;
                end
            end

            assign rdata[r*DATA_W +: DATA_W] = val;
        end
    endgenerate

endmodule
`default_nettype wire
